// File: rtl/multi_dispatcher.sv
// Multi-lane dispatcher: a circular instruction queue that issues up to DISPATCH_WIDTH
// instructions per cycle into reservation stations and ROB entries, with in-group bypass.
package multi_dispatcher_pkg;
  localparam int unsigned ROB_IDX_W = 3;
  localparam int unsigned RS_IDX_W  = 2;
  localparam int unsigned NUM_FU    = 4;

  localparam logic [1:0] FU_SLOT_CP0    = 2'd0;
  localparam logic [1:0] FU_SLOT_BRANCH = 2'd1;
  localparam logic [1:0] FU_SLOT_LSU    = 2'd2;
  localparam logic [1:0] FU_SLOT_ALU    = 2'd3;

  typedef logic [ROB_IDX_W-1:0] rob_index_t;
  typedef logic [RS_IDX_W-1:0]  rs_index_t;

  typedef enum logic [2:0] {
    FU_NONE, FU_ALU, FU_LOAD, FU_STORE, FU_BRANCH, FU_CP0
  } fu_t;

  typedef struct packed {
    logic [31:0] vaddr;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    fu_t        fu;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       use_imm;
    logic       imm_signed;
  } decoded_instr_t;

  typedef struct packed {
    logic       busy;
    rob_index_t reorder;
  } register_status_t;

  typedef struct packed {
    logic                busy;
    rs_index_t           index;
    rob_index_t          reorder;
    logic [1:0][31:0]    operand_data;
    logic [1:0]          operand_ready;
    rob_index_t [1:0]    operand_addr;
    decoded_instr_t      decoded;
    fetch_entry_t        fetch;
    logic [31:0]         instr;
  } reserve_station_t;

  typedef struct packed {
    logic        valid;
    logic        busy;
    logic        done;
    logic        exception;
    logic [31:0] pc;
    logic [31:0] value;
    logic [4:0]  dest;
    fu_t         fu;
    logic        delayslot;
  } rob_entry_t;

  typedef struct packed {
    fetch_entry_t   fetch;
    decoded_instr_t decoded;
    logic           delayslot;
  } queue_entry_t;
endpackage

module multi_dispatcher
  import multi_dispatcher_pkg::*;
#(
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned QUEUE_DEPTH    = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic                                   stall,
  input  logic [DISPATCH_WIDTH-1:0]              in_valid,
  input  fetch_entry_t [DISPATCH_WIDTH-1:0]      in_fetch,
  input  decoded_instr_t [DISPATCH_WIDTH-1:0]    in_decoded,
  input  logic [DISPATCH_WIDTH-1:0]              in_delayslot,
  output logic                                   in_ready,
  input  rob_index_t                             rob_tail,
  input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]    rob_free,
  input  logic                                   rob_empty,
  output logic [DISPATCH_WIDTH-1:0][1:0][4:0]    reg_raddr,
  input  logic [DISPATCH_WIDTH-1:0][1:0][31:0]   reg_rdata,
  input  register_status_t [DISPATCH_WIDTH-1:0][1:0] reg_status,
  input  logic [3:0]                             fu_ready,
  input  rs_index_t [3:0]                        fu_index,
  output logic [3:0]                             fu_taken,
  output logic [3:0][((DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1)-1:0] fu_lane,
  output reserve_station_t [DISPATCH_WIDTH-1:0]  rs,
  output rob_entry_t [DISPATCH_WIDTH-1:0]        rob,
  output logic [$clog2(DISPATCH_WIDTH+1)-1:0]    dispatch_cnt
);
  localparam int unsigned W      = DISPATCH_WIDTH;
  localparam int unsigned D      = QUEUE_DEPTH;
  localparam int unsigned PTR_W  = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned CNT_W  = $clog2(D + 1);
  localparam int unsigned DCNT_W = $clog2(W + 1);
  localparam int unsigned LANE_W = (W > 1) ? $clog2(W) : 1;

  queue_entry_t     mem [D];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [DCNT_W-1:0] push_n;
  logic [W-1:0]     go;
  queue_entry_t     lane_entry [W];
  rob_index_t       lane_reorder [W];

  // Bit 2 flags that the class owns an FU slot; bits 1:0 select the slot.
  function automatic logic [2:0] fu_slot(input fu_t fu);
    logic [2:0] r;
    r = '0;
    case (fu)
      FU_ALU:            r = {1'b1, FU_SLOT_ALU};
      FU_LOAD, FU_STORE: r = {1'b1, FU_SLOT_LSU};
      FU_BRANCH:         r = {1'b1, FU_SLOT_BRANCH};
      FU_CP0:            r = {1'b1, FU_SLOT_CP0};
      default:           r = '0;
    endcase
    return r;
  endfunction

  assign in_ready = (int'(D) - int'(count)) >= int'(W);

  // Push length is the run of valid lanes starting at lane 0.
  always_comb begin
    push_n = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (in_ready && !flush && !rst && in_valid[i] && int'(push_n) == i)
        push_n = DCNT_W'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(W); i++) begin
      if (i < int'(push_n))
        mem[tail + PTR_W'(i)] <= '{fetch: in_fetch[i], decoded: in_decoded[i],
                                   delayslot: in_delayslot[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(dispatch_cnt);
      tail  <= tail + PTR_W'(push_n);
      count <= count + CNT_W'(push_n) - CNT_W'(dispatch_cnt);
    end
  end

  always_comb begin
    for (int k = 0; k < int'(W); k++) begin
      lane_entry[k]   = mem[head + PTR_W'(k)];
      lane_reorder[k] = rob_tail + rob_index_t'(k);
      reg_raddr[k][0] = lane_entry[k].decoded.rs1;
      reg_raddr[k][1] = lane_entry[k].decoded.rs2;
    end
  end

  // In-order lane selection: a lane issues only if every lower lane issued.
  always_comb begin
    logic       chain;
    logic       lane_ok;
    logic [2:0] cls;
    go           = '0;
    fu_taken     = '0;
    fu_lane      = '0;
    dispatch_cnt = '0;
    chain        = !rst && !flush && !stall;
    for (int k = 0; k < int'(W); k++) begin
      cls     = fu_slot(lane_entry[k].decoded.fu);
      lane_ok = chain && (int'(count) > k) && (int'(rob_free) > k);
      if (cls[2])
        lane_ok = lane_ok && fu_ready[cls[1:0]] && !fu_taken[cls[1:0]];
      if (lane_entry[k].decoded.fu == FU_CP0)
        lane_ok = lane_ok && (k == 0) && rob_empty;
      go[k] = lane_ok;
      chain = lane_ok && (lane_entry[k].decoded.fu != FU_CP0);
      if (lane_ok) begin
        dispatch_cnt = dispatch_cnt + DCNT_W'(1);
        if (cls[2]) begin
          fu_taken[cls[1:0]] = 1'b1;
          fu_lane[cls[1:0]]  = LANE_W'(k);
        end
      end
    end
  end

  always_comb begin
    logic [2:0] cls;
    logic [4:0] src;
    for (int k = 0; k < int'(W); k++) begin
      cls           = fu_slot(lane_entry[k].decoded.fu);
      rs[k]         = '0;
      rs[k].busy    = go[k] && cls[2];
      rs[k].index   = (cls[2] && cls[1:0] != FU_SLOT_CP0) ? fu_index[cls[1:0]] : '0;
      rs[k].reorder = lane_reorder[k];
      rs[k].decoded = lane_entry[k].decoded;
      rs[k].fetch   = lane_entry[k].fetch;
      rs[k].instr   = lane_entry[k].fetch.instr;
      for (int i = 0; i < 2; i++) begin
        src = (i == 0) ? lane_entry[k].decoded.rs1 : lane_entry[k].decoded.rs2;
        rs[k].operand_data[i]  = reg_rdata[k][i];
        rs[k].operand_ready[i] = !reg_status[k][i].busy;
        rs[k].operand_addr[i]  = reg_status[k][i].reorder;
        // Highest issuing lower lane writing this source wins.
        for (int j = 0; j < k; j++) begin
          if (go[j] && lane_entry[j].decoded.rd != 5'd0 && lane_entry[j].decoded.rd == src) begin
            rs[k].operand_ready[i] = 1'b0;
            rs[k].operand_addr[i]  = lane_reorder[j];
          end
        end
      end
      if (lane_entry[k].decoded.use_imm) begin
        rs[k].operand_data[1]  = lane_entry[k].decoded.imm_signed
                               ? {{16{lane_entry[k].fetch.instr[15]}}, lane_entry[k].fetch.instr[15:0]}
                               : {16'd0, lane_entry[k].fetch.instr[15:0]};
        rs[k].operand_ready[1] = 1'b1;
        rs[k].operand_addr[1]  = '0;
      end
      rob[k]           = '0;
      rob[k].valid     = go[k];
      rob[k].busy      = rs[k].busy;
      rob[k].pc        = lane_entry[k].fetch.vaddr;
      rob[k].dest      = lane_entry[k].decoded.rd;
      rob[k].fu        = lane_entry[k].decoded.fu;
      rob[k].delayslot = lane_entry[k].delayslot;
    end
  end
endmodule

// File: doc/multi_dispatcher.md
MULTI_DISPATCHER -- requirements
Module: multi_dispatcher

Interface
REQ-001 Parameter DISPATCH_WIDTH (W), default 2: lanes pushed/dispatched per cycle, range 1..4.
REQ-002 Parameter QUEUE_DEPTH (D), default 4: instruction-queue entries, power of two, D >= W.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 flush  in  1  pipeline flush (mispredict/exception).
REQ-006 stall  in  1  back-end stall; blocks dispatch, not push.
REQ-007 in_valid  in  W  per-lane push valid, contiguous from lane 0.
REQ-008 in_fetch  in  W x fetch_entry_t  fetch entries.
REQ-009 in_decoded  in  W x decoded_instr_t  decoded instructions.
REQ-010 in_delayslot  in  W  delay-slot flags.
REQ-011 in_ready  out  1  queue accepts a full W-wide group.
REQ-012 rob_tail  in  rob_index_t  next free ROB index.
REQ-013 rob_free  in  $clog2(W+1)  free ROB slots, saturated at W.
REQ-014 rob_empty  in  1  ROB holds no valid entry.
REQ-015 reg_raddr  out  W x 2 x 5  source register addresses of queue lanes 0..W-1.
REQ-016 reg_rdata  in  W x 2 x uint32_t; reg_status  in  W x 2 x register_status_t  per-lane operand data/status.
REQ-017 fu_ready  in  4 (ALU, LSU, BRANCH, CP0); fu_index  in  4 x rs_index_t (CP0 index unused).
REQ-018 fu_taken  out  4  FU slot consumed; fu_lane  out  4 x $clog2(W) (min 1 bit)  lane using it.
REQ-019 rs  out  W x reserve_station_t; rob  out  W x rob_entry_t; dispatch_cnt  out  $clog2(W+1).

Function
REQ-020 Queue is circular over D entries: head/tail pointers $clog2(D) bits, natural wrap; count $clog2(D+1) bits.
REQ-021 in_ready = (D - count) >= W, from registered count only (same-cycle pops ignored).
REQ-022 Push when in_ready & ~flush: entries for lanes 0..n-1 written at tail in lane order, n = valid lanes before first in_valid=0; later lanes ignored.
REQ-023 Lane k examines queue entry head+k; reg_raddr[k] = decoded rs1/rs2 of that entry whether or not valid.
REQ-024 Lane k dispatches iff: count > k; lanes 0..k-1 dispatch; ~stall; ~flush; rob_free > k; its FU class fu_ready=1 and not taken by a lower lane this cycle (one instruction per FU per cycle).
REQ-025 FU_LOAD and FU_STORE share the LSU slot.
REQ-026 FU_CP0 dispatches only in lane 0 with rob_empty=1; no higher lane dispatches that cycle.
REQ-027 Other FU classes need no FU slot: ROB entry only, rob.busy=0, rs.busy=0.
REQ-028 dispatch_cnt = number of dispatching lanes; head += dispatch_cnt, count += pushed - dispatch_cnt, same edge.
REQ-029 Lane k reorder = rob_tail + k, wrapping in rob_index_t width; rs[k].reorder equals it.
REQ-030 rs[k] operand i: data reg_rdata, ready ~reg_status.busy, addr reg_status.reorder; if use_imm, operand 1 = imm (instr[15:0], bit 15 extended only when imm_signed), ready 1.
REQ-031 Intra-group bypass: if highest lower lane j dispatching this cycle has dest = lane k source and dest != 0, operand ready 0 and addr = reorder of lane j (overrides status, not imm).
REQ-032 rs[k].busy = lane dispatches and class has an RS; rs.index = fu_index of class, 0 for CP0; decoded/fetch/instr copied from entry.
REQ-033 rob[k]: all fields 0 except valid = lane dispatches, busy = rs[k].busy, pc = fetch.vaddr, dest = rd, fu, delayslot.
REQ-034 fu_taken[f] = 1 iff a dispatching lane uses f; fu_lane[f] = that lane, else 0.
REQ-035 flush: count, head, tail <= 0 next edge; that cycle no dispatch, push dropped, all valid/busy/taken outputs 0.

Reset
REQ-036 During rst: no dispatch, same-cycle push dropped; head, tail, count <= 0 next edge; afterwards in_ready=1, dispatch_cnt=0, fu_taken=0, all rs.busy/rob.valid 0.
REQ-037 rst overrides flush and push; reset mid-group discards every queued entry.

Verification
REQ-038 Reset, push ALU+ALU (rd=3; rs1=3), all ready, rob_tail=5 -> lane1 ALU blocked; next cycle lane0 rd=3 reorder 5 dispatches, later lane1 dispatches with reorder 6.
REQ-039 Push ALU rd=3 then LSU rs1=3, rob_tail=7, rob_free=2 -> dispatch_cnt=2, rs[1].operand_ready[0]=0, operand_addr[0]=7, reorder 8 (wrap if ROB size 8 -> 0).
REQ-040 Push 4 groups with stall=1, D=4 -> in_ready=0 after 2 groups; pushes 3-4 dropped; release stall -> 4 entries in order over 2 cycles.
REQ-041 CP0 at head, rob_empty=0 -> dispatch_cnt=0 until rob_empty=1; then dispatch_cnt=1, fu_taken=0001 (CP0 bit) only.
REQ-042 Queue count 3, flush with in_valid=11 -> no outputs; next cycle count=0, in_ready=1.
REQ-043 rob_free=1, two ready ALU/BRANCH -> dispatch_cnt=1, lane1 rob.valid=0.
